// File: rtl/case_1_mul_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module : case_1_mul_pipe_hs
// Pipelined signed/unsigned multiplier with valid/ready handshake, wrap
// truncation and sticky overflow. Define CASE_1_MUL_SAT_EN to clamp instead.
// Rev    : 1.0  initial release
// ============================================================================
module case_1_mul_pipe_hs #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 12,
   parameter int din1_WIDTH = 6,
   parameter int dout_WIDTH = 12
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  din_vld,
   output logic                  din_rdy,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  is_signed,
   output logic                  dout_vld,
   input  logic                  dout_rdy,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf,
   input  logic                  ovf_clr
);
   localparam int c_PW   = din0_WIDTH + din1_WIDTH;
   localparam int c_LAST = NUM_STAGE - 1;
   localparam int c_HW   = c_PW - dout_WIDTH + 1;

   logic                  w_adv;
   logic [c_PW-1:0]       w_a_ext;
   logic [c_PW-1:0]       w_b_ext;
   logic [c_PW-1:0]       w_prod;
   logic [c_HW-1:0]       w_hi;
   logic                  w_ovf_s;
   logic                  w_ovf_u;
   logic                  w_ovf_new;
   logic [dout_WIDTH-1:0] w_fin_res;

   logic                  w_in_vld [NUM_STAGE];
   logic                  w_in_ovf [NUM_STAGE];
   logic [dout_WIDTH-1:0] w_in_res [NUM_STAGE];
   logic                  r_vld    [NUM_STAGE];
   logic                  r_ovf    [NUM_STAGE];
   logic [dout_WIDTH-1:0] r_res    [NUM_STAGE];
   logic                  r_ovf_flag;
`ifdef CASE_1_MUL_SAT_EN
   localparam logic [dout_WIDTH-1:0] c_SMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
   localparam logic [dout_WIDTH-1:0] c_SMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
   logic                  w_in_sgn [NUM_STAGE];
   logic                  w_in_neg [NUM_STAGE];
   logic                  r_sgn    [NUM_STAGE];
   logic                  r_neg    [NUM_STAGE];
`endif

   assign w_adv   = dout_rdy | ~r_vld[c_LAST];
   assign din_rdy = w_adv;

   // Extending both operands to the full product width makes the low c_PW
   // bits of a plain multiply exact in either mode.
   assign w_a_ext = is_signed ? {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0}
                              : {{din1_WIDTH{1'b0}}, din0};
   assign w_b_ext = is_signed ? {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1}
                              : {{din0_WIDTH{1'b0}}, din1};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_hi      = w_prod[c_PW-1:dout_WIDTH-1];
   assign w_ovf_s   = ~((&w_hi) | ~(|w_hi));
   assign w_ovf_u   = |(w_prod >> dout_WIDTH);
   assign w_ovf_new = is_signed ? w_ovf_s : w_ovf_u;

   always_comb begin
      w_in_vld[0] = din_vld;
      w_in_ovf[0] = w_ovf_new;
      w_in_res[0] = w_prod[dout_WIDTH-1:0];
`ifdef CASE_1_MUL_SAT_EN
      w_in_sgn[0] = is_signed;
      w_in_neg[0] = w_prod[c_PW-1];
`endif
      for (int k = 1; k < NUM_STAGE; k++) begin
         w_in_vld[k] = r_vld[k-1];
         w_in_ovf[k] = r_ovf[k-1];
         w_in_res[k] = r_res[k-1];
`ifdef CASE_1_MUL_SAT_EN
         w_in_sgn[k] = r_sgn[k-1];
         w_in_neg[k] = r_neg[k-1];
`endif
      end
   end

   // Value loaded into the output register; clamping lives here only.
`ifdef CASE_1_MUL_SAT_EN
   always_comb begin
      w_fin_res = w_in_res[c_LAST];
      if (w_in_ovf[c_LAST]) begin
         if (w_in_sgn[c_LAST])
            w_fin_res = w_in_neg[c_LAST] ? c_SMIN : c_SMAX;
         else
            w_fin_res = '1;
      end
   end
`else
   assign w_fin_res = w_in_res[c_LAST];
`endif

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int k = 0; k < NUM_STAGE; k++) begin
            r_vld[k] <= 1'b0;
            r_ovf[k] <= 1'b0;
            r_res[k] <= '0;
`ifdef CASE_1_MUL_SAT_EN
            r_sgn[k] <= 1'b0;
            r_neg[k] <= 1'b0;
`endif
         end
         r_ovf_flag <= 1'b0;
      end else begin
         if (w_adv) begin
            for (int k = 0; k < NUM_STAGE; k++) begin
               r_vld[k] <= w_in_vld[k];
               // Data only moves with a valid token so dout holds across bubbles.
               if (w_in_vld[k]) begin
                  r_ovf[k] <= w_in_ovf[k];
                  r_res[k] <= (k == c_LAST) ? w_fin_res : w_in_res[k];
`ifdef CASE_1_MUL_SAT_EN
                  r_sgn[k] <= w_in_sgn[k];
                  r_neg[k] <= w_in_neg[k];
`endif
               end
            end
         end
         r_ovf_flag <= (r_vld[c_LAST] & dout_rdy & r_ovf[c_LAST]) |
                       (r_ovf_flag & ~ovf_clr);
      end
   end

   assign dout_vld = r_vld[c_LAST];
   assign dout     = r_res[c_LAST];
   assign ovf      = r_ovf_flag;

endmodule
`default_nettype wire

// File: tb/tb_case_1_mul_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module : tb_case_1_mul_pipe_hs
// Directed self-checking bench for case_1_mul_pipe_hs at three configurations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_case_1_mul_pipe_hs;
   typedef struct {
      logic [11:0] a;
      logic [5:0]  b;
      logic        sg;
      logic [11:0] wrap;
      logic [11:0] sat;
      logic        ov;
   } vec_t;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        din_vld  [3];
   logic        din_rdy  [3];
   logic        sgn      [3];
   logic        dout_vld [3];
   logic        dout_rdy [3];
   logic        ovf      [3];
   logic        ovf_clr  [3];
   logic [15:0] a [3];
   logic [15:0] b [3];
   logic [31:0] q [3];
   logic [11:0] q0;
   logic [11:0] q1;
   logic [31:0] q8;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 ap_clk = ~ap_clk;

   assign q[0] = {20'd0, q0};
   assign q[1] = {20'd0, q1};
   assign q[2] = q8;

   case_1_mul_pipe_hs #(.ID(1), .NUM_STAGE(2), .din0_WIDTH(12), .din1_WIDTH(6), .dout_WIDTH(12)) u_s2 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_vld(din_vld[0]), .din_rdy(din_rdy[0]),
      .din0(a[0][11:0]), .din1(b[0][5:0]), .is_signed(sgn[0]), .dout_vld(dout_vld[0]),
      .dout_rdy(dout_rdy[0]), .dout(q0), .ovf(ovf[0]), .ovf_clr(ovf_clr[0]));

   case_1_mul_pipe_hs #(.ID(2), .NUM_STAGE(1), .din0_WIDTH(12), .din1_WIDTH(6), .dout_WIDTH(12)) u_s1 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_vld(din_vld[1]), .din_rdy(din_rdy[1]),
      .din0(a[1][11:0]), .din1(b[1][5:0]), .is_signed(sgn[1]), .dout_vld(dout_vld[1]),
      .dout_rdy(dout_rdy[1]), .dout(q1), .ovf(ovf[1]), .ovf_clr(ovf_clr[1]));

   case_1_mul_pipe_hs #(.ID(3), .NUM_STAGE(8), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(32)) u_s8 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_vld(din_vld[2]), .din_rdy(din_rdy[2]),
      .din0(a[2]), .din1(b[2]), .is_signed(sgn[2]), .dout_vld(dout_vld[2]),
      .dout_rdy(dout_rdy[2]), .dout(q8), .ovf(ovf[2]), .ovf_clr(ovf_clr[2]));

   function automatic int ns(input int s);
      return (s == 0) ? 2 : ((s == 1) ? 1 : 8);
   endfunction

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic test_reset;
      ap_rst_n = 1'b0;
      #2;
      for (int s = 0; s < 3; s++) begin
         n_cmp++;
         if (dout_vld[s] !== 1'b0 || q[s] !== 32'd0 || ovf[s] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got vld=%b dout=%0h ovf=%b expected 0/0/0", s, dout_vld[s], q[s], ovf[s]);
         end
      end
      tick;
      tick;
      #2 ap_rst_n = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) begin
         n_cmp++;
         if (din_rdy[s] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_din_rdy[%0d]: got %b expected 1", s, din_rdy[s]);
         end
      end
      tick;
   endtask

   task automatic test_vectors;
      vec_t        vt [10];
      logic [11:0] exp_v;
      vt[0] = '{12'd100, 6'h3D, 1'b1, 12'hED4, 12'hED4, 1'b0};
      vt[1] = '{12'h7FF, 6'h01, 1'b1, 12'h7FF, 12'h7FF, 1'b0};
      vt[2] = '{12'h7FF, 6'h02, 1'b1, 12'hFFE, 12'h7FF, 1'b1};
      vt[3] = '{12'h800, 6'h01, 1'b1, 12'h800, 12'h800, 1'b0};
      vt[4] = '{12'h800, 6'h3F, 1'b1, 12'h800, 12'h7FF, 1'b1};
      vt[5] = '{12'hFFF, 6'h01, 1'b0, 12'hFFF, 12'hFFF, 1'b0};
      vt[6] = '{12'h800, 6'h02, 1'b0, 12'h000, 12'hFFF, 1'b1};
      vt[7] = '{12'h801, 6'h02, 1'b1, 12'h002, 12'h800, 1'b1};
      vt[8] = '{12'h800, 6'h20, 1'b1, 12'h000, 12'h7FF, 1'b1};
      vt[9] = '{12'hFFF, 6'h3F, 1'b0, 12'hFC1, 12'hFFF, 1'b1};
      for (int i = 0; i < 10; i++) begin
`ifdef CASE_1_MUL_SAT_EN
         exp_v = vt[i].sat;
`else
         exp_v = vt[i].wrap;
`endif
         a[0] = {4'd0, vt[i].a};
         b[0] = {10'd0, vt[i].b};
         sgn[0] = vt[i].sg;
         din_vld[0] = 1'b1;
         tick;
         din_vld[0] = 1'b0;
         for (int j = 1; j < ns(0); j++) begin
            n_cmp++;
            if (dout_vld[0] !== 1'b0) begin
               n_err++;
               $display("FAIL vec%0d_early: got dout_vld=%b expected 0", i, dout_vld[0]);
            end
            tick;
         end
         n_cmp++;
         if (dout_vld[0] !== 1'b1 || q0 !== exp_v || ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL vec%0d_result: got vld=%b dout=%h ovf=%b expected 1/%h/0", i, dout_vld[0], q0, ovf[0], exp_v);
         end
         tick;
         n_cmp++;
         if (ovf[0] !== vt[i].ov) begin
            n_err++;
            $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf[0], vt[i].ov);
         end
         ovf_clr[0] = 1'b1;
         tick;
         ovf_clr[0] = 1'b0;
         n_cmp++;
         if (ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL vec%0d_ovf_clr: got %b expected 0", i, ovf[0]);
         end
      end
   endtask

   task automatic test_ovf_priority;
      a[0] = 16'h0800;
      b[0] = 16'h003F;
      sgn[0] = 1'b1;
      din_vld[0] = 1'b1;
      tick;
      din_vld[0] = 1'b0;
      tick;
      ovf_clr[0] = 1'b1;
      tick;
      n_cmp++;
      if (ovf[0] !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_set_wins: got %b expected 1", ovf[0]);
      end
      tick;
      ovf_clr[0] = 1'b0;
      n_cmp++;
      if (ovf[0] !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clr_after: got %b expected 0", ovf[0]);
      end
   endtask

   task automatic test_stream(input int s);
      int exp_q[$];
      int sent  = 0;
      int got   = 0;
      int first = -1;
      for (int c = 0; c < 80 && got < 10; c++) begin
         din_vld[s]  = (sent < 10);
         a[s]        = 16'(sent);
         b[s]        = 16'(sent + 1);
         sgn[s]      = 1'b0;
         dout_rdy[s] = !(c >= 4 && c <= 7);
         #1;
         if (dout_vld[s] === 1'b1 && first < 0) begin
            first = c;
            n_cmp++;
            if (first != ns(s)) begin
               n_err++;
               $display("FAIL stream%0d_latency: got %0d expected %0d", s, first, ns(s));
            end
         end
         if (dout_rdy[s] == 1'b0 && dout_vld[s] === 1'b1) begin
            n_cmp++;
            if (din_rdy[s] !== 1'b0) begin
               n_err++;
               $display("FAIL stream%0d_stall_rdy: got din_rdy=%b expected 0 at cycle %0d", s, din_rdy[s], c);
            end
         end
         if (dout_vld[s] === 1'b1 && dout_rdy[s] == 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL stream%0d_extra: got %0d expected no output", s, q[s]);
            end else begin
               if (q[s] !== 32'(exp_q[0])) begin
                  n_err++;
                  $display("FAIL stream%0d_value: got %0d expected %0d", s, q[s], exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            got++;
         end
         if (din_vld[s] && din_rdy[s] === 1'b1) begin
            exp_q.push_back(sent * (sent + 1));
            sent++;
         end
         tick;
      end
      din_vld[s]  = 1'b0;
      dout_rdy[s] = 1'b1;
      n_cmp++;
      if (got != 10 || exp_q.size() != 0 || sent != 10) begin
         n_err++;
         $display("FAIL stream%0d_count: got %0d outputs (%0d sent, %0d pending) expected 10", s, got, sent, exp_q.size());
      end
      #1;
      n_cmp++;
      if (dout_vld[s] !== 1'b0) begin
         n_err++;
         $display("FAIL stream%0d_drained: got dout_vld=%b expected 0", s, dout_vld[s]);
      end
   endtask

   task automatic test_reset_midflight;
      a[0] = 16'd5;
      b[0] = 16'd6;
      sgn[0] = 1'b0;
      din_vld[0] = 1'b1;
      tick;
      a[0] = 16'd7;
      b[0] = 16'd3;
      tick;
      din_vld[0] = 1'b0;
      n_cmp++;
      if (dout_vld[0] !== 1'b1 || q0 !== 12'd30) begin
         n_err++;
         $display("FAIL rst_pre: got vld=%b dout=%0d expected 1/30", dout_vld[0], q0);
      end
      #2 ap_rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dout_vld[0] !== 1'b0 || q0 !== 12'd0 || din_rdy[0] !== 1'b1) begin
         n_err++;
         $display("FAIL rst_async: got vld=%b dout=%0d rdy=%b expected 0/0/1", dout_vld[0], q0, din_rdy[0]);
      end
      #2 ap_rst_n = 1'b1;
      tick;
      a[0] = 16'd7;
      b[0] = 16'd9;
      din_vld[0] = 1'b1;
      tick;
      din_vld[0] = 1'b0;
      for (int j = 1; j < ns(0); j++) begin
         n_cmp++;
         if (dout_vld[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stale: got dout_vld=%b expected 0", dout_vld[0]);
         end
         tick;
      end
      n_cmp++;
      if (dout_vld[0] !== 1'b1 || q0 !== 12'd63) begin
         n_err++;
         $display("FAIL rst_after: got vld=%b dout=%0d expected 1/63", dout_vld[0], q0);
      end
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      for (int s = 0; s < 3; s++) begin
         din_vld[s]  = 1'b0;
         dout_rdy[s] = 1'b1;
         ovf_clr[s]  = 1'b0;
         sgn[s]      = 1'b0;
         a[s]        = 16'd0;
         b[s]        = 16'd0;
      end
      test_reset;
      test_vectors;
      test_ovf_priority;
      test_stream(0);
      test_stream(1);
      test_stream(2);
      test_reset_midflight;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
